// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding used by both TX and RX,
// default line timing, and the baud tick divisor derived from it.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   localparam int unsigned UART_OVERSAMPLING = 16;
   localparam int unsigned UART_BAUD_RATE    = 19200;
   localparam int unsigned UART_CLK_FREQ     = 50_000_000;

   // Rounded to nearest so the bit period error stays under half a clock per tick.
   function automatic int unsigned uart_tick_divisor(input int unsigned clk_freq,
                                                     input int unsigned baud_rate,
                                                     input int unsigned oversampling);
      int unsigned denom;
      denom = baud_rate * oversampling;
      return (clk_freq + denom / 2) / denom;
   endfunction

   localparam int unsigned UART_TICK_DIVISOR =
      uart_tick_divisor(UART_CLK_FREQ, UART_BAUD_RATE, UART_OVERSAMPLING);

   function automatic int unsigned uart_frame_ticks(input int unsigned oversampling,
                                                    input int unsigned data_bits,
                                                    input int unsigned parity_en,
                                                    input int unsigned sb_tick);
      return oversampling * (1 + data_bits + parity_en) + sb_tick;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level handshake between the byte producer (master) and the UART
// transmitter (slave).
interface uart_tx_if
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = 8
);
   logic                 i_tx_start;
   logic [DATA_BITS-1:0] i_data;
   logic                 o_busy;
   logic                 o_tx_done_tick;

   modport master (
      output i_tx_start,
      output i_data,
      input  o_busy,
      input  o_tx_done_tick
   );

   modport slave (
      input  i_tx_start,
      input  i_data,
      output o_busy,
      output o_tx_done_tick
   );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// stop ticks; timed by the shared oversampling baud tick, registered line output.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned OVERSAMPLING = UART_OVERSAMPLING,
   parameter int unsigned SB_TICK      = 16,
   parameter bit          PARITY_EN    = 1'b0,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       i_rst,
   input  logic       i_tick,
   uart_tx_if.slave   tx_if,
   output logic       o_tx
);

   localparam int unsigned TICK_MAX = (OVERSAMPLING > SB_TICK) ? OVERSAMPLING : SB_TICK;
   localparam int unsigned TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
   localparam int unsigned BW       = $clog2(DATA_BITS + 1);

   localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLING - 1);
   localparam logic [TW-1:0] SB_LAST   = TW'(SB_TICK - 1);
   localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [TW-1:0]        tick_q,  tick_d;
   logic [BW-1:0]        bit_q,   bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q,   par_d;
   logic                 tx_q,    tx_d;
   logic                 busy_q,  busy_d;
   logic                 done_q,  done_d;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // A tick coincident with acceptance is not counted: IDLE never looks at i_tick.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      unique case (state_q)
         IDLE: begin
            if (tx_if.i_tx_start) begin
               state_d = START;
               shift_d = tx_if.i_data;
               par_d   = (^tx_if.i_data) ^ PARITY_ODD;
               tick_d  = '0;
            end
         end
         START: begin
            if (i_tick) begin
               if (tick_q == OS_LAST) begin
                  state_d = DATA;
                  tick_d  = '0;
                  bit_d   = '0;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (i_tick) begin
               if (tick_q == OS_LAST) begin
                  tick_d  = '0;
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 1'b1;
                  if (bit_q == BITS_LAST) begin
                     state_d = PARITY_EN ? PARITY : STOP;
                  end
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (i_tick) begin
               if (tick_q == OS_LAST) begin
                  state_d = STOP;
                  tick_d  = '0;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (i_tick) begin
               if (tick_q == SB_LAST) begin
                  state_d = IDLE;
                  tick_d  = '0;
               end else begin
                  tick_d = tick_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tick_d  = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so the registered pin changes on the transition edge.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_d != IDLE);
      done_d = (state_q == STOP) && (state_d == IDLE);
      unique case (state_d)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = par_d;
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   assign o_tx                 = tx_q;
   assign tx_if.o_busy         = busy_q;
   assign tx_if.o_tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default framing, parity variants, start/data
// while busy, back-to-back frames, mid-frame reset and a real-divisor receive.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int unsigned NONE = 32'hFFFF_FFFF;

   logic       clk = 1'b0;
   logic       rst;
   logic       tick_man;
   logic       use_div;
   logic       tick;
   logic [7:0] divcnt = '0;
   logic [7:0] data;
   logic       start0, start1, start2;
   logic       tx0, tx1, tx2;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic        rx_t;
   logic [7:0]  rx_byte;
   int unsigned rx_ticks;
   logic        rx_done;

   uart_tx_if #(.DATA_BITS(8)) bus0 ();
   uart_tx_if #(.DATA_BITS(8)) bus1 ();
   uart_tx_if #(.DATA_BITS(8)) bus2 ();

   assign bus0.i_tx_start = start0;
   assign bus1.i_tx_start = start1;
   assign bus2.i_tx_start = start2;
   assign bus0.i_data     = data;
   assign bus1.i_data     = data;
   assign bus2.i_data     = data;

   uart_tx #(.DATA_BITS(8)) u_dut0 (
      .clk(clk), .i_rst(rst), .i_tick(tick), .tx_if(bus0), .o_tx(tx0)
   );
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut1 (
      .clk(clk), .i_rst(rst), .i_tick(tick), .tx_if(bus1), .o_tx(tx1)
   );
   uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut2 (
      .clk(clk), .i_rst(rst), .i_tick(tick), .tx_if(bus2), .o_tx(tx2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) divcnt <= (divcnt == 8'd162) ? 8'd0 : divcnt + 8'd1;
   assign tick = use_div ? (divcnt == 8'd162) : tick_man;

   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   function automatic logic [2:0] obs(input int unsigned sel);
      case (sel)
         0:       return {tx0, bus0.o_busy, bus0.o_tx_done_tick};
         1:       return {tx1, bus1.o_busy, bus1.o_tx_done_tick};
         default: return {tx2, bus2.o_busy, bus2.o_tx_done_tick};
      endcase
   endfunction

   task automatic set_start(input int unsigned sel, input logic v);
      case (sel)
         0:       start0 = v;
         1:       start1 = v;
         default: start2 = v;
      endcase
   endtask

   task automatic send(input int unsigned sel, input logic [7:0] d);
      data = d;
      set_start(sel, 1'b1);
      step(1);
      set_start(sel, 1'b0);
   endtask

   // Called one cycle into the frame with i_tick high every clk; checks
   // {o_tx, o_busy, o_tx_done_tick} on every cycle and the done cycle after.
   task automatic frame_check(input int unsigned sel, input string tag, input logic [7:0] d,
                              input int unsigned pen, input logic pval,
                              input int unsigned poke_at);
      int unsigned len;
      len = 16 * (9 + pen) + 16;
      for (int unsigned k = 0; k < len; k++) begin
         int unsigned b;
         logic        e;
         b = k / 16;
         if (b == 0)                   e = 1'b0;
         else if (b <= 8)              e = d[b-1];
         else if (pen != 0 && b == 9)  e = pval;
         else                          e = 1'b1;
         chk(tag, 32'(obs(sel)), 32'({e, 2'b10}));
         if (k == poke_at) begin
            data = 8'hFF;
            set_start(sel, 1'b1);
            step(1);
            set_start(sel, 1'b0);
         end else begin
            step(1);
         end
      end
      chk({tag, "_done"}, 32'(obs(sel)), 32'(3'b101));
   endtask

   initial begin
      rst      = 1'b1;
      tick_man = 1'b1;
      use_div  = 1'b0;
      data     = '0;
      start0   = 1'b0;
      start1   = 1'b0;
      start2   = 1'b0;
      step(2);
      chk("reset0", 32'(obs(0)), 32'(3'b100));
      chk("reset1", 32'(obs(1)), 32'(3'b100));
      chk("reset2", 32'(obs(2)), 32'(3'b100));

      // no ticks: accepted frame sits in START indefinitely
      rst      = 1'b0;
      tick_man = 1'b0;
      step(1);
      send(0, 8'h5A);
      chk("hold_accept", 32'(obs(0)), 32'(3'b010));
      step(40);
      chk("hold_still", 32'(obs(0)), 32'(3'b010));
      tick_man = 1'b1;
      frame_check(0, "hold_frame", 8'h5A, 0, 1'b0, NONE);
      step(1);
      chk("hold_idle", 32'(obs(0)), 32'(3'b100));

      // tick tied high, tick coincident with acceptance
      send(0, 8'hA5);
      frame_check(0, "a5", 8'hA5, 0, 1'b0, NONE);
      step(1);
      chk("a5_idle", 32'(obs(0)), 32'(3'b100));

      // start and new data mid-frame are ignored
      send(0, 8'h81);
      frame_check(0, "ignore", 8'h81, 0, 1'b0, 50);
      step(1);
      chk("ignore_idle", 32'(obs(0)), 32'(3'b100));
      step(20);
      chk("ignore_quiet", 32'(obs(0)), 32'(3'b100));

      // start held high: back-to-back frames with one idle clk
      data   = 8'h55;
      start0 = 1'b1;
      step(1);
      data   = 8'hAA;
      frame_check(0, "b2b_55", 8'h55, 0, 1'b0, NONE);
      step(1);
      frame_check(0, "b2b_aa", 8'hAA, 0, 1'b0, NONE);
      start0 = 1'b0;
      step(1);
      chk("b2b_idle", 32'(obs(0)), 32'(3'b100));

      // reset during data bit 3 of 0x99 (bit3 = 1), then a clean 0x3C frame
      send(0, 8'h99);
      step(69);
      chk("rst_bit3", 32'(obs(0)), 32'(3'b110));
      rst = 1'b1;
      step(1);
      chk("rst_abort", 32'(obs(0)), 32'(3'b100));
      rst = 1'b0;
      step(1);
      chk("rst_nodone", 32'(obs(0)), 32'(3'b100));
      step(16);
      chk("rst_quiet", 32'(obs(0)), 32'(3'b100));
      send(0, 8'h3C);
      frame_check(0, "after_rst", 8'h3C, 0, 1'b0, NONE);

      // parity: 0x07 has three ones -> even parity 1, odd parity 0
      step(1);
      send(1, 8'h07);
      frame_check(1, "par_even", 8'h07, 1, 1'b1, NONE);
      step(1);
      send(2, 8'h07);
      frame_check(2, "par_odd", 8'h07, 1, 1'b0, NONE);
      step(1);

      // real divisor: bench receiver samples mid-bit by counting ticks
      use_div  = 1'b1;
      step(1);
      send(0, 8'hE2);
      rx_byte  = '0;
      rx_ticks = 0;
      rx_done  = 1'b0;
      for (int c = 0; c < 30000 && !rx_done; c++) begin
         rx_t = tick;
         step(1);
         if (rx_t) begin
            rx_ticks++;
            if (rx_ticks == 8)
               chk("rx_start", 32'(tx0), 32'(1'b0));
            else if (rx_ticks >= 24 && rx_ticks <= 136 && ((rx_ticks - 8) % 16) == 0)
               rx_byte[(rx_ticks - 24) / 16] = tx0;
            else if (rx_ticks == 152)
               chk("rx_stop", 32'(tx0), 32'(1'b1));
         end
         if (bus0.o_tx_done_tick) rx_done = 1'b1;
      end
      chk("rx_done", 32'(rx_done), 32'(1'b1));
      chk("rx_byte", 32'(rx_byte), 32'(8'hE2));
      chk("rx_ticks", rx_ticks, 32'd160);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
